// File: rtl/booth_mult_seq.sv
// ---------------------------------------------------------------------------
// booth_mult_seq
//   Sequential radix-2 Booth multiplier. It multiplies two signed N-bit
//   operands into a signed 2N-bit product, retiring one Booth step per clock.
//   A start/busy/done handshake connects it to operand registers upstream
//   and to a result consumer downstream.
//
//   Timing: start accepted at edge k -> N Booth steps on edges k+1..k+N ->
//   product and a one-cycle done pulse appear after edge k+N+1. A new start
//   can be accepted while done is high.
//
// Parameters
//   N             operand width (two's complement), N >= 2
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   start         operation request, sampled only while idle
//   multiplicand  signed operand M, captured when start is accepted
//   multiplier    signed operand Q, captured when start is accepted
//   accumulate    (BOOTH_MAC_EN only) add the new product to the previous one
//   busy          operation in progress
//   done          one-cycle pulse, product valid from this cycle
//   product       signed 2N-bit result, held until the next completion
//
// Build option
//   BOOTH_MAC_EN  when defined, adds the accumulate port and a 2N-bit
//                 wrap-around adder on the product path.
// ---------------------------------------------------------------------------
module booth_mult_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
`ifdef BOOTH_MAC_EN
  input  logic           accumulate,
`endif
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t           state_r;
  // A and M carry one extra bit so that A - M cannot overflow when
  // M is the most negative operand value.
  logic [N:0]       a_r;
  logic [N:0]       m_r;
  logic [N-1:0]     q_r;
  logic             qm1_r;
  logic [CW-1:0]    count_r;
  logic             busy_r;
  logic             done_r;
  logic [2*N-1:0]   product_r;
`ifdef BOOTH_MAC_EN
  logic             acc_r;
`endif

  logic [N:0]       sum_s;
  logic [2*N-1:0]   booth_prod_s;
  logic [2*N-1:0]   next_product_s;

  // Booth recoding of the current multiplier bit pair selects add, subtract or hold.
  always_comb begin
    sum_s = a_r;
    case ({q_r[0], qm1_r})
      2'b01:   sum_s = a_r + m_r;
      2'b10:   sum_s = a_r - m_r;
      default: sum_s = a_r;
    endcase
  end

  // Final product assembly; the low N bits of A already hold the exact upper half.
  always_comb begin
    booth_prod_s   = {a_r[N-1:0], q_r};
    next_product_s = booth_prod_s;
`ifdef BOOTH_MAC_EN
    if (acc_r) begin
      next_product_s = product_r + booth_prod_s;
    end else begin
      next_product_s = booth_prod_s;
    end
`endif
  end

  // Control FSM and datapath registers, including the registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      a_r       <= {(N+1){1'b0}};
      m_r       <= {(N+1){1'b0}};
      q_r       <= {N{1'b0}};
      qm1_r     <= 1'b0;
      count_r   <= {CW{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= {(2*N){1'b0}};
`ifdef BOOTH_MAC_EN
      acc_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            a_r     <= {(N+1){1'b0}};
            m_r     <= {multiplicand[N-1], multiplicand};
            q_r     <= multiplier;
            qm1_r   <= 1'b0;
            count_r <= CW'(N);
            busy_r  <= 1'b1;
`ifdef BOOTH_MAC_EN
            acc_r   <= accumulate;
`endif
            state_r <= ST_CALC;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_CALC: begin
          // Arithmetic right shift of {A', Q, Q_-1}; the A sign bit replicates.
          a_r     <= {sum_s[N], sum_s[N:1]};
          q_r     <= {sum_s[0], q_r[N-1:1]};
          qm1_r   <= q_r[0];
          count_r <= count_r - CW'(1);
          if (count_r == CW'(1)) begin
            state_r <= ST_FINISH;
          end else begin
            state_r <= ST_CALC;
          end
        end

        ST_FINISH: begin
          product_r <= next_product_s;
          done_r    <= 1'b1;
          busy_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end

        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

endmodule

// File: tb/tb_booth_mult_seq.sv
// ---------------------------------------------------------------------------
// tb_booth_mult_seq
//   Self-checking bench for booth_mult_seq. Two instances are exercised: an
//   N=8 multiplier with directed vectors and an N=3 multiplier swept over all
//   64 operand pairs. A cycle-count model per instance predicts busy, done
//   and product from plain signed arithmetic; one process compares both
//   instances against their models on every cycle, and the directed
//   sequences add hand-computed literal expectations.
//   Define BOOTH_MAC_EN to include the accumulate sequence.
// ---------------------------------------------------------------------------
module tb_booth_mult_seq;

  localparam int N8 = 8;
  localparam int N3 = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start8, start3;
  logic [7:0]  mc8, mq8;
  logic [2:0]  mc3, mq3;
`ifdef BOOTH_MAC_EN
  logic        acc8, acc3;
`endif
  logic        busy8, done8, busy3, done3;
  logic [15:0] prod8;
  logic [5:0]  prod3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  booth_mult_seq #(.N(N8)) dut8 (
    .clk(clk), .reset(reset), .start(start8),
    .multiplicand(mc8), .multiplier(mq8),
`ifdef BOOTH_MAC_EN
    .accumulate(acc8),
`endif
    .busy(busy8), .done(done8), .product(prod8)
  );

  booth_mult_seq #(.N(N3)) dut3 (
    .clk(clk), .reset(reset), .start(start3),
    .multiplicand(mc3), .multiplier(mq3),
`ifdef BOOTH_MAC_EN
    .accumulate(acc3),
`endif
    .busy(busy3), .done(done3), .product(prod3)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Behavioural model, N=8: a busy operation lasts N+1 edges after acceptance,
  // the result is the signed product of the captured operands.
  logic               mb8, md8, macc8;
  logic [15:0]        mp8;
  logic signed [15:0] ea8, eb8;
  int                 ml8;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mb8 <= 1'b0; md8 <= 1'b0; mp8 <= 16'h0000; ml8 <= 0;
    end else begin
      md8 <= 1'b0;
      if (ml8 != 0) begin
        ml8 <= ml8 - 1;
        if (ml8 == 1) begin
          mb8 <= 1'b0;
          md8 <= 1'b1;
          mp8 <= (macc8 ? mp8 : 16'h0000) + ea8 * eb8;
        end
      end else if (start8) begin
        mb8 <= 1'b1;
        ml8 <= N8 + 1;
        ea8 <= $signed(mc8);
        eb8 <= $signed(mq8);
`ifdef BOOTH_MAC_EN
        macc8 <= acc8;
`else
        macc8 <= 1'b0;
`endif
      end
    end
  end

  // Behavioural model, N=3.
  logic              mb3, md3, macc3;
  logic [5:0]        mp3;
  logic signed [5:0] ea3, eb3;
  int                ml3;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mb3 <= 1'b0; md3 <= 1'b0; mp3 <= 6'h00; ml3 <= 0;
    end else begin
      md3 <= 1'b0;
      if (ml3 != 0) begin
        ml3 <= ml3 - 1;
        if (ml3 == 1) begin
          mb3 <= 1'b0;
          md3 <= 1'b1;
          mp3 <= (macc3 ? mp3 : 6'h00) + ea3 * eb3;
        end
      end else if (start3) begin
        mb3 <= 1'b1;
        ml3 <= N3 + 1;
        ea3 <= $signed(mc3);
        eb3 <= $signed(mq3);
`ifdef BOOTH_MAC_EN
        macc3 <= acc3;
`else
        macc3 <= 1'b0;
`endif
      end
    end
  end

  // Cycle-by-cycle comparison of both instances against their models.
  always @(posedge clk) begin
    #1;
    chk("busy8", busy8, mb8);
    chk("done8", done8, md8);
    chk("prod8", prod8, mp8);
    chk("busy3", busy3, mb3);
    chk("done3", done3, md3);
    chk("prod3", prod3, mp3);
  end

  // Wait for done on the N=8 instance; latency counted in edges after acceptance.
  task automatic wait8(input string nm, input logic [15:0] exp);
    int lat;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done8) begin lat = i; break; end
    end
    chk({nm, "_lat"}, lat, N8 + 1);
    chk({nm, "_prod"}, prod8, exp);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic acc,
                      input logic [15:0] exp, input string nm);
    @(negedge clk);
    start8 = 1'b1; mc8 = a; mq8 = b;
`ifdef BOOTH_MAC_EN
    acc8 = acc;
`endif
    @(posedge clk); #1;
    start8 = 1'b0; mc8 = 8'($urandom); mq8 = 8'($urandom);
`ifdef BOOTH_MAC_EN
    acc8 = ~acc;
`endif
    chk({nm, "_busy"}, busy8, 1'b1);
    wait8(nm, exp);
  endtask

  task automatic run3(input logic [2:0] a, input logic [2:0] b,
                      input logic [5:0] exp, input string nm);
    int lat;
    @(negedge clk);
    start3 = 1'b1; mc3 = a; mq3 = b;
    @(posedge clk); #1;
    start3 = 1'b0; mc3 = 3'($urandom); mq3 = 3'($urandom);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done3) begin lat = i; break; end
    end
    chk({nm, "_lat"}, lat, N3 + 1);
    chk({nm, "_prod"}, prod3, exp);
  endtask

  initial begin
    int pulses;
    int ia, ib;
    reset  = 1'b0;
    start8 = 1'b0; mc8 = 8'h00; mq8 = 8'h00;
    start3 = 1'b0; mc3 = 3'h0;  mq3 = 3'h0;
`ifdef BOOTH_MAC_EN
    acc8 = 1'b0; acc3 = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_prod", prod8, 16'h0000);
    chk("rst_prod3", prod3, 6'h00);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Basic product and latency.
    run8(8'd3, 8'd5, 1'b0, 16'h000F, "t1_3x5");

    // Full-range and sign corner cases.
    run8(8'h80, 8'h80, 1'b0, 16'h4000, "t2_m128sq");
    run8(8'hFF, 8'h7F, 1'b0, 16'hFF81, "t2_m1x127");
    run8(8'h00, 8'hB3, 1'b0, 16'h0000, "t2_0xm77");
    run8(8'h7F, 8'h80, 1'b0, 16'hC080, "t2_127xm128");
    run8(8'h80, 8'h7F, 1'b0, 16'hC080, "t2_m128x127");

    // start held high throughout; operands change while busy.
    @(negedge clk);
    start8 = 1'b1; mc8 = 8'd3; mq8 = 8'd5;
    @(posedge clk); #1;
    mc8 = 8'hF9; mq8 = 8'd9;
    wait8("t3_first", 16'h000F);
    @(posedge clk); #1;
    chk("t3_rearm", busy8, 1'b1);
    start8 = 1'b0;
    wait8("t3_second", 16'hFFC1);

    // Reset during CALC aborts with no done pulse.
    @(negedge clk);
    start8 = 1'b1; mc8 = 8'd100; mq8 = 8'hCE;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t4_busy", busy8, 1'b0);
    chk("t4_done", done8, 1'b0);
    chk("t4_prod", prod8, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8) pulses++;
    end
    chk("t4_nodone", pulses, 0);
    run8(8'd7, 8'hFD, 1'b0, 16'hFFEB, "t4_7xm3");

    // N=3: full-range corner then exhaustive sweep against signed arithmetic.
    run3(3'b100, 3'b100, 6'b010000, "t5_m4sq");
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        ia = (a >= 4) ? a - 8 : a;
        ib = (b >= 4) ? b - 8 : b;
        run3(3'(a), 3'(b), 6'(ia * ib), "t5_sweep");
      end
    end

`ifdef BOOTH_MAC_EN
    // Accumulate: replace, add, then repeated adds that wrap modulo 2^16.
    run8(8'd3,  8'd5,   1'b0, 16'h000F, "t6_3x5");
    run8(8'd2,  8'hFC,  1'b1, 16'h0007, "t6_acc2xm4");
    run8(8'd127, 8'd127, 1'b1, 16'h3F08, "t6_acc1");
    run8(8'd127, 8'd127, 1'b1, 16'h7E09, "t6_acc2");
    run8(8'd127, 8'd127, 1'b1, 16'hBD0A, "t6_acc3");
    run8(8'd127, 8'd127, 1'b1, 16'hFC0B, "t6_acc4");
    run8(8'd127, 8'd127, 1'b1, 16'h3B0C, "t6_wrap");
    run8(8'd3,  8'd5,   1'b0, 16'h000F, "t6_replace");
`endif

    repeat (3) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
